// File: rtl/sha512_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha512_pkg : shared SHA-512 types and padding constants
// Rev 1.0
// ----------------------------------------------------------------------------
package sha512_pkg;

  typedef logic [511:0] t_block;

  localparam int         SHA512_LINES_PER_BLOCK = 2;
  localparam int         SHA512_LEN_BYTES       = 16;
  localparam logic [7:0] SHA512_PAD_BYTE        = 8'h80;

  typedef enum logic [2:0] {
    PS_IDLE    = 3'd0,
    PS_COLLECT = 3'd1,
    PS_EMIT    = 3'd2,
    PS_EXTRA   = 3'd3,
    PS_FIN     = 3'd4
  } t_padder_state;

endpackage
`default_nettype wire

// File: rtl/sha512_pad_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha512_pad_line : masks a 64-byte line and overlays the 0x80 marker / length
// Rev 1.0
// ----------------------------------------------------------------------------
module sha512_pad_line
  import sha512_pkg::*;
(
  input  logic [511:0] line_i,
  input  logic [6:0]   vcnt_i,
  input  logic         mark_en_i,
  input  logic [5:0]   mark_idx_i,
  input  logic         len_en_i,
  input  logic [127:0] len_i,
  output logic [511:0] line_o
);

  for (genvar i = 0; i < 64; i++) begin : g_byte
    logic [7:0] len_byte;
    logic       in_len;

    // The length field occupies the top 16 bytes of the slot, MSB first.
    if (i >= 64 - SHA512_LEN_BYTES) begin : g_len
      assign len_byte = len_i[8*(63-i) +: 8];
      assign in_len   = 1'b1;
    end else begin : g_nolen
      assign len_byte = 8'h00;
      assign in_len   = 1'b0;
    end

    assign line_o[8*i +: 8] =
        (len_en_i && in_len)                 ? len_byte        :
        (mark_en_i && (mark_idx_i == 6'(i))) ? SHA512_PAD_BYTE :
        (7'(i) < vcnt_i)                     ? line_i[8*i +: 8] : 8'h00;
  end

endmodule
`default_nettype wire

// File: rtl/sha512_padder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha512_padder : pairs 512-bit message lines into padded 1024-bit SHA-512 blocks
// Rev 1.0
// ----------------------------------------------------------------------------
module sha512_padder
  import sha512_pkg::*;
#(
  parameter int MAX_LEN_W = 64
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                start_i,
  input  logic [MAX_LEN_W-1:0]                msg_bytes_i,
  input  logic [511:0]                        line_i,
  input  logic                                line_valid_i,
  output logic                                line_ready_o,
  output logic [SHA512_LINES_PER_BLOCK*512-1:0] block_o,
  output logic                                block_valid_o,
  input  logic                                ready_i,
  output logic                                busy_o,
  output logic                                done_o
);

  t_padder_state state_q, state_d;
  logic [MAX_LEN_W-1:0] lines_left_q, lines_left_d;
  logic [127:0] bitlen_q, bitlen_d;
  logic [6:0]   r_q, r_d;
  logic         slot_q, slot_d;
  logic         need_extra_q, need_extra_d;
  t_block [SHA512_LINES_PER_BLOCK-1:0] blk_q, blk_d;

  logic         is_last, r_nz;
  logic [6:0]   vc_line;
  logic [MAX_LEN_W-1:0] start_lines;

  logic [511:0] lo_line, hi_line, lo_pad, hi_pad;
  logic [6:0]   lo_vcnt, hi_vcnt;
  logic         lo_mark_en, hi_mark_en, hi_len_en;

  assign is_last     = (lines_left_q == MAX_LEN_W'(1));
  assign r_nz        = (r_q != 7'd0);
  // A zero remainder in the final line means that line is completely full.
  assign vc_line     = !is_last ? 7'd64 : (r_q[5:0] == 6'd0) ? 7'd64 : {1'b0, r_q[5:0]};
  assign start_lines = (msg_bytes_i >> 6) + MAX_LEN_W'(|msg_bytes_i[5:0]);

  always_comb begin
    lo_line    = line_i;
    lo_vcnt    = vc_line;
    lo_mark_en = is_last && r_nz && !r_q[6];
    hi_line    = slot_q ? line_i : 512'd0;
    hi_vcnt    = slot_q ? vc_line : 7'd0;
    hi_mark_en = is_last && r_nz && r_q[6];
    hi_len_en  = is_last && r_nz && (r_q <= 7'd111);
    if (state_q == PS_EXTRA) begin
      lo_line    = 512'd0;
      lo_vcnt    = 7'd0;
      lo_mark_en = !r_nz;
      hi_line    = 512'd0;
      hi_vcnt    = 7'd0;
      hi_mark_en = 1'b0;
      hi_len_en  = 1'b1;
    end
  end

  sha512_pad_line u_pad_lo (
    .line_i     (lo_line),
    .vcnt_i     (lo_vcnt),
    .mark_en_i  (lo_mark_en),
    .mark_idx_i (lo_mark_en ? r_q[5:0] : 6'd0),
    .len_en_i   (1'b0),
    .len_i      (bitlen_q),
    .line_o     (lo_pad)
  );

  sha512_pad_line u_pad_hi (
    .line_i     (hi_line),
    .vcnt_i     (hi_vcnt),
    .mark_en_i  (hi_mark_en),
    .mark_idx_i (r_q[5:0]),
    .len_en_i   (hi_len_en),
    .len_i      (bitlen_q),
    .line_o     (hi_pad)
  );

  always_comb begin
    state_d      = state_q;
    lines_left_d = lines_left_q;
    bitlen_d     = bitlen_q;
    r_d          = r_q;
    slot_d       = slot_q;
    need_extra_d = need_extra_q;
    blk_d        = blk_q;

    unique case (state_q)
      PS_IDLE: begin
        if (start_i) begin
          lines_left_d = start_lines;
          bitlen_d     = {{(128-MAX_LEN_W){1'b0}}, msg_bytes_i} << 3;
          r_d          = msg_bytes_i[6:0];
          slot_d       = 1'b0;
          need_extra_d = 1'b0;
          blk_d        = '0;
          state_d      = (start_lines == '0) ? PS_EXTRA : PS_COLLECT;
        end
      end
      PS_COLLECT: begin
        if (line_valid_i) begin
          lines_left_d = lines_left_q - MAX_LEN_W'(1);
          if (!slot_q) begin
            blk_d[0] = lo_pad;
            // A lone final line still owns the upper slot for marker/length.
            if (is_last) blk_d[1] = hi_pad;
          end else begin
            blk_d[1] = hi_pad;
          end
          if (is_last) begin
            need_extra_d = !r_nz || (r_q >= 7'd112);
            state_d      = PS_EMIT;
          end else if (slot_q) begin
            state_d = PS_EMIT;
          end else begin
            slot_d = 1'b1;
          end
        end
      end
      PS_EMIT: begin
        if (ready_i) begin
          blk_d   = '0;
          slot_d  = 1'b0;
          state_d = (lines_left_q != '0) ? PS_COLLECT :
                    need_extra_q         ? PS_EXTRA   : PS_FIN;
        end
      end
      PS_EXTRA: begin
        blk_d[0]     = lo_pad;
        blk_d[1]     = hi_pad;
        need_extra_d = 1'b0;
        state_d      = PS_EMIT;
      end
      PS_FIN: begin
        state_d = PS_IDLE;
      end
      default: begin
        state_d = PS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= PS_IDLE;
      lines_left_q <= '0;
      bitlen_q     <= '0;
      r_q          <= '0;
      slot_q       <= 1'b0;
      need_extra_q <= 1'b0;
      blk_q        <= '0;
    end else begin
      state_q      <= state_d;
      lines_left_q <= lines_left_d;
      bitlen_q     <= bitlen_d;
      r_q          <= r_d;
      slot_q       <= slot_d;
      need_extra_q <= need_extra_d;
      blk_q        <= blk_d;
    end
  end

  assign line_ready_o  = (state_q == PS_COLLECT);
  assign block_valid_o = (state_q == PS_EMIT) && ready_i;
  assign busy_o        = (state_q == PS_COLLECT) || (state_q == PS_EMIT) || (state_q == PS_EXTRA);
  assign done_o        = (state_q == PS_FIN);
  assign block_o       = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_sha512_padder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sha512_padder : directed table plus random messages against a FIPS padding model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sha512_padder;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [63:0]   msg_bytes_i;
  logic [511:0]  line_i;
  logic          line_valid_i;
  logic          line_ready_o;
  logic [1023:0] block_o;
  logic          block_valid_o;
  logic          ready_i;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  sha512_padder #(.MAX_LEN_W(64)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .msg_bytes_i   (msg_bytes_i),
    .line_i        (line_i),
    .line_valid_i  (line_valid_i),
    .line_ready_o  (line_ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]    mem [0:1023];
  logic [7:0]    pad [0:1023];
  logic [1023:0] exp_q [$];
  logic [1023:0] got_blk [0:15];
  int            nb;

  typedef struct {
    int         len;
    int         stall;
    bit         abc;
    int         nblk;
    int         pb0;
    int         pi0;
    logic [7:0] pv0;
    int         pb1;
    int         pi1;
    logic [7:0] pv1;
  } vec_t;

  task automatic chk_val(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    int k;
    checks++;
    if (got !== exp) begin
      failures++;
      k = -1;
      for (int j = 0; j < 128; j++)
        if (k < 0 && got[8*j +: 8] !== exp[8*j +: 8]) k = j;
      if (k < 0) k = 0;
      $display("FAIL %s byte=%0d got=%h exp=%h", name, k, got[8*k +: 8], exp[8*k +: 8]);
    end
  endtask

  // Padded message = data, 0x80, zeros to 112 mod 128, 16-byte big-endian bit length.
  task automatic build_expected(input int len);
    int            p;
    logic [127:0]  bl;
    logic [1023:0] b;
    for (int i = 0; i < len; i++) pad[i] = mem[i];
    pad[len] = 8'h80;
    p = len + 1;
    while (p % 128 != 112) begin
      pad[p] = 8'h00;
      p++;
    end
    bl = 128'(len) * 128'd8;
    for (int k = 0; k < 16; k++) pad[p+k] = bl[127-8*k -: 8];
    p += 16;
    for (int n = 0; n < p / 128; n++) begin
      b = '0;
      for (int j = 0; j < 128; j++) b[8*j +: 8] = pad[128*n + j];
      exp_q.push_back(b);
    end
  endtask

  task automatic send_msg(input int len, input int stall, input bit abc);
    int nlines, idx, cyc, last_bv, wcnt, li;
    bit lr, bz, acc, fin;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    if (abc) begin
      mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    end
    exp_q.delete();
    build_expected(len);
    nb = 0; nlines = (len + 63) / 64; idx = 0; cyc = 0; last_bv = -10; wcnt = 0; fin = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; msg_bytes_i = 64'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk_val("busy_after_start", longint'(busy_o), 1);
    while (!fin) begin
      lr = line_ready_o;
      bz = busy_o;
      line_valid_i = (idx < nlines) && ($urandom % 4 != 0);
      li = (idx < nlines) ? idx : 0;
      for (int j = 0; j < 64; j++) line_i[8*j +: 8] = mem[64*li + j];
      if (stall > 0) begin
        if (!lr && bz) wcnt++; else wcnt = 0;
        ready_i = (wcnt > stall);
      end else begin
        ready_i = ($urandom % 4 != 0);
      end
      start_i     = bz && ($urandom % 8 == 0);
      msg_bytes_i = {$urandom, $urandom};
      #1;
      acc = line_valid_i && lr;
      if (stall > 0 && !ready_i && wcnt >= 2 && exp_q.size() > 0)
        chk_blk("stall_hold", block_o, exp_q[0]);
      if (block_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_block got=%0d exp=%0d", nb + 1, nb);
        end else begin
          chk_blk("block", block_o, exp_q.pop_front());
        end
        if (nb < 16) got_blk[nb] = block_o;
        nb++;
        last_bv = cyc;
      end
      if (done_o) begin
        chk_val("done_timing", cyc - last_bv, 1);
        chk_val("busy_at_done", longint'(busy_o), 0);
        fin = 1;
      end else if (cyc > 3000) begin
        checks++; failures++;
        $display("FAIL timeout len=%0d got=%0d exp=%0d", len, cyc, 3000);
        fin = 1;
      end else begin
        @(posedge clk_i); #1;
        if (acc) idx++;
        cyc++;
      end
    end
    start_i = 1'b0; line_valid_i = 1'b0; ready_i = 1'b0;
    chk_val("lines_taken", idx, nlines);
    chk_val("blocks_left", exp_q.size(), 0);
  endtask

  vec_t          vecs [5];
  int            bl_lens [12];
  logic [1023:0] exp3;
  int            len;

  initial begin
    reset_i = 1'b1; start_i = 1'b0; msg_bytes_i = '0; line_i = '0;
    line_valid_i = 1'b0; ready_i = 1'b1;
    vecs[0] = '{0,   0,  1'b0, 1, 0, 0,   8'h80, 0, 127, 8'h00};
    vecs[1] = '{3,   0,  1'b1, 1, 0, 3,   8'h80, 0, 127, 8'h18};
    vecs[2] = '{112, 0,  1'b0, 2, 0, 112, 8'h80, 1, 127, 8'h80};
    vecs[3] = '{128, 0,  1'b0, 2, 1, 0,   8'h80, 1, 126, 8'h04};
    vecs[4] = '{200, 10, 1'b0, 2, 1, 72,  8'h80, 1, 127, 8'h40};
    bl_lens = '{1, 63, 64, 65, 111, 112, 113, 127, 128, 129, 191, 256};

    repeat (3) @(posedge clk_i);
    #1;
    chk_val("rst_line_ready", longint'(line_ready_o), 0);
    chk_val("rst_block_valid", longint'(block_valid_o), 0);
    chk_val("rst_busy", longint'(busy_o), 0);
    chk_val("rst_done", longint'(done_o), 0);
    chk_blk("rst_block", block_o, '0);
    reset_i = 1'b0;

    foreach (vecs[v]) begin
      send_msg(vecs[v].len, vecs[v].stall, vecs[v].abc);
      chk_val("nblk", nb, vecs[v].nblk);
      chk_val("probe0", longint'(got_blk[vecs[v].pb0][8*vecs[v].pi0 +: 8]), longint'(vecs[v].pv0));
      chk_val("probe1", longint'(got_blk[vecs[v].pb1][8*vecs[v].pi1 +: 8]), longint'(vecs[v].pv1));
    end

    // Abort a 256-byte message after one line; nothing of it may reach the core.
    @(posedge clk_i); #1;
    start_i = 1'b1; msg_bytes_i = 64'd256;
    @(posedge clk_i); #1;
    start_i = 1'b0; line_valid_i = 1'b1; line_i = {16{$urandom}}; ready_i = 1'b1;
    @(posedge clk_i); #1;
    line_valid_i = 1'b0;
    chk_val("abort_busy", longint'(busy_o), 1);
    reset_i = 1'b1;
    #1;
    chk_val("arst_line_ready", longint'(line_ready_o), 0);
    chk_val("arst_busy", longint'(busy_o), 0);
    chk_blk("arst_block", block_o, '0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    line_valid_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      chk_val("post_abort_quiet", longint'({block_valid_o, done_o, busy_o, line_ready_o}), 0);
    end
    line_valid_i = 1'b0;
    send_msg(3, 0, 1'b1);
    exp3 = '0;
    exp3[7:0] = 8'h61; exp3[15:8] = 8'h62; exp3[23:16] = 8'h63; exp3[31:24] = 8'h80;
    exp3[1023:1016] = 8'h18;
    chk_val("len3_nblk", nb, 1);
    chk_blk("len3_after_reset", got_blk[0], exp3);

    for (int m = 0; m < 25; m++) begin
      if ($urandom % 3 == 0) len = bl_lens[$urandom_range(0, 11)];
      else len = int'($urandom_range(0, 600));
      send_msg(len, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha512_padder.md
# sha512_padder

Streaming SHA-512 message padder between `sha512_requestor` and the `sha512` core. Accepts 512-bit cache lines of the message in order and pairs them into 1024-bit blocks (`t_block block[2]`). Applies FIPS 180-4 padding: 0x80 marker, zero fill, 128-bit big-endian bit length. Hands each block to the core under the core's `ready`/`block_valid` handshake. Emits the extra pad-only block when one is required.

## Interface
- `MAX_LEN_W`, default 64: width of the message byte count.
- `clk`  in  1  single clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse; latches `msg_bytes`; honoured only in IDLE.
- `msg_bytes`  in  MAX_LEN_W  message length in bytes.
- `line`  in  512 (`t_block`)  message cache line. Byte i sits at bits [8i+7:8i].
- `line_valid`  in  1  `line` is valid.
- `line_ready`  out  1  padder accepts `line` this cycle.
- `block`  out  2x512 (`t_block [2]`)  `block[0]` = bytes 0–63, `block[1]` = bytes 64–127.
- `block_valid`  out  1  one-cycle pulse; `block` is valid and the core takes it.
- `ready`  in  1  core can accept a block.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse after the final block is issued.

## Operation
- States:
  - IDLE → COLLECT on `start`.
  - COLLECT → EMIT when block slot 1 is filled, or when the last message line is accepted.
  - EMIT → COLLECT (more lines), EXTRA (pad-only block needed) or FIN.
  - EXTRA → EMIT.
  - FIN → IDLE.
- `start` latches:
  - `lines_left = ceil(msg_bytes/64)`.
  - `bitlen = msg_bytes << 3`, zero-extended to 128 bits.
  - `r = msg_bytes mod 128`.
- COLLECT:
  - `line_ready = 1`.
  - Each accepted line goes to slot `lo` first, then slot `hi`.
  - Each accepted line decrements `lines_left`.
- `lines_left == 0` at `start` (len 0): go directly to EXTRA.
- On accepting the last line (`lines_left == 1`):
  - In the final line, bytes at message index ≥ `msg_bytes` are forced to 0.
  - If `r != 0`, byte index `r` is set to 0x80. If that index falls in the unfilled slot, the 0x80 is placed there; all other unfilled bytes are 0.
  - If `r <= 111` and `r != 0`: write the length into bytes 112–127 (byte 112 = MSB, byte 127 = LSB of `bitlen`). This is the final block.
  - If `r >= 112` or `r == 0`: no length in this block; `need_extra = 1`.
- EXTRA builds the pad-only block:
  - bytes 0–111 = 0, except byte 0 = 0x80 when `r == 0` (this also covers len 0);
  - bytes 112–127 = length.
  - For `r >= 112` the 0x80 was already placed in the data block.
- EMIT: `block_valid` is asserted in the first EMIT cycle with `ready == 1`, for exactly one cycle. Then both slots are cleared.
- `start` while `busy`: ignored. `line_valid` outside COLLECT: ignored (`line_ready = 0`).
- Reset in any state:
  - next edge in IDLE, slots zeroed;
  - no block or `done` is emitted for the aborted message.

## Timing
- Reset values: `line_ready`, `block_valid`, `busy`, `done` = 0; `block` = all zeros.
- Lines are accepted at one per cycle in COLLECT.
- Last accepted line at cycle N → EMIT at N+1. `block_valid` at the earliest cycle ≥ N+1 with `ready`.
- Full 2-line block: `line_ready` is 0 from the acceptance of the `hi` line until `block_valid`.
- `block` is registered and stable for the whole of EMIT.
- `block` may change only after `block_valid`.
- `done` comes 1 cycle after the last `block_valid`. `busy` falls with `done`.
- Odd line count: the final block holds one data line; slot `hi` holds padding/length only.
- Length arithmetic: `msg_bytes` up to 2^64−1. `bitlen` never overflows 128 bits.

## Structure
- Add to `sha512_pkg`:
  - `t_block` (shared);
  - `SHA512_LINES_PER_BLOCK = 2`;
  - `SHA512_LEN_BYTES = 16`;
  - `SHA512_PAD_BYTE = 8'h80`;
  - enum `t_padder_state`.
- Sub-module `sha512_pad_line`: combinational. Inputs: line, valid-byte count 0–64, marker enable, marker index, length enable, 128-bit length. Output: masked/padded 512-bit line. Used once per slot.

## Test plan
- len 0, `start` → one block: byte0 = 0x80, all other bytes 0 including length; `done` 1 cycle later.
- len 3, line bytes 61 62 63 + garbage → one block:
  - bytes 0–3 = 61 62 63 80;
  - bytes 4–126 = 0;
  - byte 127 = 0x18.
- len 112, two lines:
  - block A: bytes 0–111 data, byte 112 = 0x80, rest 0;
  - block B: all 0 except bytes 126–127 = 0x03 0x80.
- len 128 → block A = 2 data lines unmodified; block B = byte0 0x80, bytes 126–127 = 0x04 0x00.
- len 200, `ready` held low 10 cycles during each EMIT:
  - `line_ready` stays 0;
  - `block` is stable;
  - exactly 2 `block_valid` pulses;
  - block B has bytes 0–71 data, byte 72 = 0x80, bytes 126–127 = 0x06 0x40.
- Reset asserted mid-COLLECT of a 256-byte message → outputs return to reset values. A following len-3 message yields the exact block from the len-3 scenario.
